wb_read_buffer: RTL and testbench

WB_READ_BUFFER -- requirements
Module: wb_read_buffer

---
 rtl/wb_read_buffer.sv | 184 ++++++++++++++++++
 tb/tb_wb_read_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_read_buffer.sv
// wb_read_buffer: single-line read buffer on the narrow side of a Wishbone
// upsizer. Read hits are answered locally one cycle after the request.
// Misses and all writes go downstream as classic single cycles. A write that
// hits the buffered line merges its enabled bytes into the line.
// Optional hit/miss counters: define WB_READ_BUFFER_STATS_EN.
module wb_read_buffer #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            flush_i,
  // upstream slave side
  input  logic [AW-1:0]   wbs_adr_i,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic [DW/8-1:0] wbs_sel_i,
  input  logic            wbs_we_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic [2:0]      wbs_cti_i,
  input  logic [1:0]      wbs_bte_i,
  output logic [DW-1:0]   wbs_dat_o,
  output logic            wbs_ack_o,
  output logic            wbs_err_o,
  output logic            wbs_rty_o,
  // downstream master side
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic            wbm_we_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic [2:0]      wbm_cti_o,
  output logic [1:0]      wbm_bte_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  input  logic            wbm_rty_i
`ifdef WB_READ_BUFFER_STATS_EN
  ,
  output logic [31:0]     hit_cnt_o,
  output logic [31:0]     miss_cnt_o
`endif
);

  localparam int SW  = DW / 8;
  localparam int LSB = $clog2(SW);
  localparam int TW  = AW - LSB;

  typedef enum logic [1:0] {S_IDLE, S_HIT, S_READ, S_WRITE} state_t;

  state_t          r_state, w_next;
  logic            r_valid;
  logic [DW-1:0]   r_line;
  logic [TW-1:0]   r_tag;
  logic [AW-1:0]   r_adr;
  logic [DW-1:0]   r_dat;
  logic [SW-1:0]   r_sel;

  logic            w_req, w_hit, w_busy, w_abort;
  logic            w_ack, w_err, w_rty, w_done;
  logic            w_line_match;
  logic [DW-1:0]   w_merged;
  logic            w_unused;

  // burst qualifiers and byte offset bits carry no meaning for a single line
  assign w_unused = ^{wbs_cti_i, wbs_bte_i, wbs_adr_i[LSB-1:0]};

  assign w_req        = wbs_cyc_i & wbs_stb_i;
  assign w_hit        = r_valid && (r_tag == wbs_adr_i[AW-1:LSB]);
  assign w_busy       = (r_state == S_READ) || (r_state == S_WRITE);
  assign w_abort      = w_busy & ~wbs_cyc_i;
  // Downstream responses are only honoured while a cycle is outstanding and
  // the master is still present; ack > err > rty keeps them one-hot.
  assign w_ack        = w_busy & wbs_cyc_i & wbm_ack_i;
  assign w_err        = w_busy & wbs_cyc_i & wbm_err_i & ~wbm_ack_i;
  assign w_rty        = w_busy & wbs_cyc_i & wbm_rty_i & ~wbm_ack_i & ~wbm_err_i;
  assign w_done       = w_ack | w_err | w_rty;
  assign w_line_match = r_valid && (r_tag == r_adr[AW-1:LSB]);

  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_sel_o = r_sel;
  assign wbm_we_o  = (r_state == S_WRITE);
  assign wbm_cyc_o = w_busy;
  assign wbm_stb_o = w_busy;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;

  // byte-lane merge of the pending write into the buffered line
  always_comb begin
    w_merged = r_line;
    for (int unsigned b = 0; b < SW; b++) begin
      if (r_sel[b]) w_merged[b*8 +: 8] = r_dat[b*8 +: 8];
    end
  end

  // state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // next-state and upstream response decode
  always_comb begin
    w_next    = r_state;
    wbs_ack_o = 1'b0;
    wbs_err_o = 1'b0;
    wbs_rty_o = 1'b0;
    wbs_dat_o = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (wbs_we_i)   w_next = S_WRITE;
          else if (w_hit) w_next = S_HIT;
          else            w_next = S_READ;
        end
      end
      S_HIT: begin
        wbs_ack_o = 1'b1;
        wbs_dat_o = r_line;
        w_next    = S_IDLE;
      end
      S_READ, S_WRITE: begin
        wbs_ack_o = w_ack;
        wbs_err_o = w_err;
        wbs_rty_o = w_rty;
        if (r_state == S_READ) wbs_dat_o = wbm_dat_i;
        if (w_done || w_abort) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // capture the downstream request when leaving IDLE for the bus
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_adr <= '0;
      r_dat <= '0;
      r_sel <= '0;
    end else if (r_state == S_IDLE && w_req && (wbs_we_i || !w_hit)) begin
      r_adr <= wbs_adr_i;
      if (wbs_we_i) begin
        r_dat <= wbs_dat_i;
        r_sel <= wbs_sel_i;
      end else begin
        r_sel <= '1;
      end
    end
  end

  // line contents: fill on read ack, merge on write-hit ack; flush wins
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_valid <= 1'b0;
      r_line  <= '0;
      r_tag   <= '0;
    end else begin
      if (r_state == S_READ && w_ack) begin
        r_line <= wbm_dat_i;
        r_tag  <= r_adr[AW-1:LSB];
      end else if (r_state == S_WRITE && w_ack && w_line_match && !flush_i) begin
        r_line <= w_merged;
      end
      if (flush_i)                        r_valid <= 1'b0;
      else if (r_state == S_READ && w_ack) r_valid <= 1'b1;
      else if (w_err)                      r_valid <= 1'b0;
    end
  end

`ifdef WB_READ_BUFFER_STATS_EN
  // count entries into HIT and READ
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_next == S_HIT)  hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (w_next == S_READ) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_read_buffer.sv
// Directed bench for wb_read_buffer with a transaction-level model of the
// buffered line and the downstream memory.
module tb_wb_read_buffer;

  logic        wb_clk_i, wb_rst_i, flush_i;
  logic [31:0] wbs_adr_i;
  logic [63:0] wbs_dat_i;
  logic [7:0]  wbs_sel_i;
  logic        wbs_we_i, wbs_cyc_i, wbs_stb_i;
  logic [2:0]  wbs_cti_i;
  logic [1:0]  wbs_bte_i;
  logic [63:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [31:0] wbm_adr_o;
  logic [63:0] wbm_dat_o;
  logic [7:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [63:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
`ifdef WB_READ_BUFFER_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  wb_read_buffer #(.AW(32), .DW(64)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .flush_i(flush_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .wbs_rty_o(wbs_rty_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .wbm_rty_i(wbm_rty_i)
`ifdef WB_READ_BUFFER_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // model: one line (valid/tag/data) and the downstream memory, by line index
  bit          m_valid;
  logic [28:0] m_tag;
  logic [63:0] m_line;
  logic [63:0] mem [logic [28:0]];

  logic [63:0] last_dat;
  int          last_lat;
  bit          last_dn;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [28:0] idx);
    if (mem.exists(idx)) return mem[idx];
    return {32'hC0DE0000 | 32'(idx), ~32'(idx)};
  endfunction

  function automatic logic [63:0] mrg(input logic [63:0] old, input logic [63:0] nw,
                                     input logic [7:0] sel);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (sel[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // resp: 0 ack, 1 err, 2 rty; dly: extra downstream wait cycles;
  // fl: assert flush in the cycle the downstream response is given
  task automatic acc(input bit we, input logic [31:0] adr, input logic [63:0] dat,
                     input logic [7:0] sel, input int resp, input int dly,
                     input bit fl, input string nm);
    bit hit, got, dn;
    int lat, dc;
    logic a, e, r;
    logic [63:0] d;
    logic [28:0] tg;
    tg  = adr[31:3];
    hit = !we && m_valid && (m_tag == tg);
    got = 0; dn = 0; lat = 0; dc = 0; a = 0; e = 0; r = 0; d = '0;
    @(negedge wb_clk_i);
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge wb_clk_i);
      if (wbm_cyc_o) begin
        if (!dn) begin
          chk({nm, " dn_adr"}, 64'(wbm_adr_o), 64'(adr));
          chk({nm, " dn_we"}, 64'(wbm_we_o), 64'(we));
          chk({nm, " dn_sel"}, 64'(wbm_sel_o), we ? 64'(sel) : 64'hFF);
          if (we) chk({nm, " dn_dat"}, wbm_dat_o, dat);
        end
        dn = 1;
        dc++;
        if (dc > dly) begin
          wbm_ack_i = (resp == 0);
          wbm_err_i = (resp == 1);
          wbm_rty_i = (resp == 2);
          wbm_dat_i = mem_rd(tg);
          flush_i   = fl;
        end
      end
      #1;
      if (wbs_ack_o || wbs_err_o || wbs_rty_o) begin
        got = 1; lat = k;
        a = wbs_ack_o; e = wbs_err_o; r = wbs_rty_o; d = wbs_dat_o;
      end
    end
    chk({nm, " responded"}, 64'(got), 64'd1);
    chk({nm, " latency"}, 64'(lat), hit ? 64'd1 : 64'(1 + dly));
    chk({nm, " downstream_used"}, 64'(dn), 64'(!hit));
    if (hit) begin
      chk({nm, " ack_err_rty"}, 64'({a, e, r}), 64'b100);
      chk({nm, " hit_dat"}, d, m_line);
    end else begin
      chk({nm, " ack_err_rty"}, 64'({a, e, r}),
          resp == 0 ? 64'b100 : resp == 1 ? 64'b010 : 64'b001);
      if (!we && resp == 0) chk({nm, " rd_dat"}, d, mem_rd(tg));
    end
    last_dat = d; last_lat = lat; last_dn = dn;
    if (!hit) begin
      if (resp == 0) begin
        if (we) begin
          mem[tg] = mrg(mem_rd(tg), dat, sel);
          if (m_valid && m_tag == tg) m_line = mrg(m_line, dat, sel);
        end else begin
          m_line = mem_rd(tg); m_tag = tg; m_valid = 1;
        end
      end else if (resp == 1) begin
        m_valid = 0;
      end
    end
    if (fl) m_valid = 0;
    @(negedge wb_clk_i);
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0; flush_i = 0;
    #1;
    chk({nm, " cyc_dropped"}, 64'(wbm_cyc_o), 64'd0);
  endtask

  task automatic rd(input logic [31:0] adr, input int resp, input int dly, input string nm);
    acc(1'b0, adr, 64'h0, 8'h00, resp, dly, 1'b0, nm);
  endtask

  task automatic flush_pulse();
    @(negedge wb_clk_i); flush_i = 1;
    @(negedge wb_clk_i); flush_i = 0;
    m_valid = 0;
  endtask

  // per-cycle checks of the rules that hold on every cycle
  always @(negedge wb_clk_i) begin
    #3;
    chk("cti_bte_zero", 64'({wbm_cti_o, wbm_bte_o}), 64'd0);
    chk("resp_onehot", 64'((32'(wbs_ack_o) + 32'(wbs_err_o) + 32'(wbs_rty_o)) <= 1), 64'd1);
    chk("stb_eq_cyc", 64'(wbm_stb_o), 64'(wbm_cyc_o));
  end

  initial begin
`ifdef WB_READ_BUFFER_STATS_EN
    logic [31:0] h0, m0;
`endif
    wb_rst_i = 1; flush_i = 0;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0; wbs_we_i = 0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_cti_i = 3'b010; wbs_bte_i = 2'b01;
    wbm_dat_i = '0; wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
    m_valid = 0; m_tag = '0; m_line = '0;
    mem[29'h20] = 64'h1122334455667788;
    #2;
    chk("rst_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("rst_outs", 64'({wbm_stb_o, wbm_we_o, wbs_ack_o, wbs_err_o, wbs_rty_o}), 64'd0);
    chk("rst_adr", 64'(wbm_adr_o), 64'd0);
    chk("rst_dat", wbm_dat_o | wbs_dat_o, 64'd0);
    chk("rst_sel", 64'(wbm_sel_o), 64'd0);
`ifdef WB_READ_BUFFER_STATS_EN
    chk("rst_cnt", {hit_cnt_o, miss_cnt_o}, 64'd0);
`endif
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 0;

    // miss then hit on the same line
    rd(32'h100, 0, 0, "rd100_miss");
    chk("lit_rd100_dat", last_dat, 64'h1122334455667788);
    rd(32'h104, 0, 0, "rd104_hit");
    chk("lit_rd104_dat", last_dat, 64'h1122334455667788);
    chk("lit_rd104_lat", 64'(last_lat), 64'd1);
    chk("lit_rd104_nodn", 64'(last_dn), 64'd0);

    // write-hit merges upper bytes
    acc(1'b1, 32'h104, 64'hAABBCCDD_00000000, 8'hF0, 0, 0, 1'b0, "wr104");
    rd(32'h100, 0, 0, "rd100_merged");
    chk("lit_merged", last_dat, 64'hAABBCCDD55667788);

    // write-miss leaves the line alone; retry leaves it alone
    acc(1'b1, 32'h208, 64'h0123456789ABCDEF, 8'h0F, 0, 1, 1'b0, "wr208_miss");
    rd(32'h100, 0, 0, "rd100_after_wrmiss");
    rd(32'h400, 2, 0, "rd400_rty");
    rd(32'h100, 0, 0, "rd100_after_rty");

    // flush pulse forces the next read downstream
    flush_pulse();
    rd(32'h100, 0, 2, "rd100_after_flush");

    // flush coincident with the filling ack leaves the line invalid
    acc(1'b0, 32'h180, 64'h0, 8'h00, 0, 0, 1'b1, "rd180_flush_ack");
    rd(32'h180, 0, 0, "rd180_again");

    // downstream error: err passed up, next read misses
    rd(32'h200, 1, 0, "rd200_err");
    rd(32'h200, 0, 0, "rd200_miss");

    // abort an outstanding read by dropping cyc
    @(negedge wb_clk_i);
    wbs_adr_i = 32'h300; wbs_we_i = 0; wbs_cyc_i = 1; wbs_stb_i = 1;
    @(negedge wb_clk_i); #1;
    chk("abort_cyc_up", 64'(wbm_cyc_o), 64'd1);
    @(negedge wb_clk_i);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    #1;
    chk("abort_no_ack", 64'(wbs_ack_o), 64'd0);
    @(negedge wb_clk_i); #1;
    chk("abort_cyc_down", 64'(wbm_cyc_o), 64'd0);
    rd(32'h200, 0, 0, "rd200_after_abort");

    // stray downstream ack in IDLE is ignored
    @(negedge wb_clk_i);
    wbm_ack_i = 1; wbm_err_i = 1;
    #1;
    chk("idle_ack_ignored", 64'({wbs_ack_o, wbs_err_o}), 64'd0);
    @(negedge wb_clk_i);
    wbm_ack_i = 0; wbm_err_i = 0;
    rd(32'h200, 0, 0, "rd200_after_stray");

`ifdef WB_READ_BUFFER_STATS_EN
    flush_pulse();
    h0 = hit_cnt_o; m0 = miss_cnt_o;
    rd(32'h500, 0, 0, "st_miss");
    rd(32'h500, 0, 0, "st_hit1");
    rd(32'h504, 0, 0, "st_hit2");
    rd(32'h500, 0, 0, "st_hit3");
    chk("stat_miss", 64'(miss_cnt_o - m0), 64'd1);
    chk("stat_hit", 64'(hit_cnt_o - h0), 64'd3);
`endif

    // write error invalidates the line
    rd(32'h500, 0, 0, "rd500");
    acc(1'b1, 32'h500, 64'h5555, 8'h03, 1, 0, 1'b0, "wr500_err");
    rd(32'h500, 0, 0, "rd500_after_werr");

    // asynchronous reset in the middle of a read
    @(negedge wb_clk_i);
    wbs_adr_i = 32'h600; wbs_we_i = 0; wbs_cyc_i = 1; wbs_stb_i = 1;
    @(negedge wb_clk_i); #1;
    chk("midrst_cyc_up", 64'(wbm_cyc_o), 64'd1);
    #1;
    wb_rst_i = 1;
    #1;
    chk("midrst_cyc", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 64'd0);
    chk("midrst_resp", 64'({wbs_ack_o, wbs_err_o, wbs_rty_o}), 64'd0);
    chk("midrst_adr", 64'(wbm_adr_o), 64'd0);
    chk("midrst_sel", 64'(wbm_sel_o), 64'd0);
    chk("midrst_dat", wbm_dat_o | wbs_dat_o, 64'd0);
    @(negedge wb_clk_i);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    m_valid = 0; m_tag = '0; m_line = '0;
    @(negedge wb_clk_i);
    wb_rst_i = 0;
    rd(32'h500, 0, 0, "rd500_after_rst");
    rd(32'h500, 0, 0, "rd500_hit_after_rst");

    @(negedge wb_clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
